// File: rtl/ddr3_axi_burst_responder.sv
// AXI4 burst responder: splits AW/W/AR bursts into single-word requests
// on a req/accept/ack memory port and returns B and R responses.
module ddr3_axi_burst_responder (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        awvalid_i,
    input  logic [31:0] awaddr_i,
    input  logic [4:0]  awid_i,
    input  logic [7:0]  awlen_i,
    input  logic [1:0]  awburst_i,
    output logic        awready_o,
    input  logic        wvalid_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wlast_i,
    output logic        wready_o,
    output logic        bvalid_o,
    output logic [1:0]  bresp_o,
    output logic [4:0]  bid_o,
    input  logic        bready_i,
    input  logic        arvalid_i,
    input  logic [31:0] araddr_i,
    input  logic [4:0]  arid_i,
    input  logic [7:0]  arlen_i,
    input  logic [1:0]  arburst_i,
    output logic        arready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic [4:0]  rid_o,
    output logic        rlast_o,
    input  logic        rready_i,
    output logic        ram_wr_o,
    output logic        ram_rd_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_wstrb_o,
    output logic [31:0] ram_write_data_o,
    input  logic        ram_accept_i,
    input  logic        ram_ack_i,
    input  logic [31:0] ram_read_data_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_READ
    } state_t;

    state_t      state_q, state_d;
    logic        wr_prio_q, wr_prio_d;
    logic        pending_q, pending_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  id_q, id_d;
    logic [7:0]  len_q, len_d;
    logic [1:0]  burst_q, burst_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic [8:0]  iss_q, iss_d;
    logic        wdone_q, wdone_d;
    logic [4:0]  bid_q, bid_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rid_q, rid_d;
    logic        rlast_q, rlast_d;

    logic        sel_w;
    logic        sel_r;
    logic        ack_take;
    logic [31:0] addr_nxt;
    logic        unused_wlast;

    // Framing comes from awlen, so wlast carries no information here.
    assign unused_wlast = wlast_i;

    function automatic logic [31:0] next_addr(
        input logic [31:0] a,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic [31:0] inc;
        logic [31:0] mask;
        logic        wrap_ok;
        inc     = a + 32'd4;
        mask    = {22'd0, len, 2'b11};
        wrap_ok = (len == 8'd1) || (len == 8'd3) ||
                  (len == 8'd7) || (len == 8'd15);
        if (burst == 2'b00) begin
            next_addr = a;
        end else if (burst == 2'b10 && wrap_ok) begin
            next_addr = (a & ~mask) | (inc & mask);
        end else begin
            next_addr = inc;
        end
    endfunction

    assign addr_nxt = next_addr(addr_q, len_q, burst_q);
    assign ack_take = ram_ack_i & pending_q;

    always_comb begin
        state_d    = state_q;
        wr_prio_d  = wr_prio_q;
        pending_d  = pending_q;
        addr_d     = addr_q;
        id_d       = id_q;
        len_d      = len_q;
        burst_d    = burst_q;
        beat_cnt_d = beat_cnt_q;
        iss_d      = iss_q;
        wdone_d    = wdone_q;
        bid_d      = bid_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rid_d      = rid_q;
        rlast_d    = rlast_q;
        sel_w      = 1'b0;
        sel_r      = 1'b0;
        awready_o  = 1'b0;
        arready_o  = 1'b0;
        wready_o   = 1'b0;
        bvalid_o   = 1'b0;
        ram_wr_o   = 1'b0;
        ram_rd_o   = 1'b0;

        if (ack_take) begin
            pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                sel_w = awvalid_i & (~arvalid_i | wr_prio_q);
                sel_r = arvalid_i & (~awvalid_i | ~wr_prio_q);
                if (sel_w) begin
                    awready_o  = 1'b1;
                    state_d    = ST_WRITE;
                    addr_d     = awaddr_i;
                    id_d       = awid_i;
                    len_d      = awlen_i;
                    burst_d    = awburst_i;
                    beat_cnt_d = 8'd0;
                    wdone_d    = 1'b0;
                    if (arvalid_i) begin
                        wr_prio_d = 1'b0;
                    end
                end else if (sel_r) begin
                    arready_o  = 1'b1;
                    state_d    = ST_READ;
                    addr_d     = araddr_i;
                    id_d       = arid_i;
                    len_d      = arlen_i;
                    burst_d    = arburst_i;
                    beat_cnt_d = 8'd0;
                    iss_d      = 9'd0;
                    if (awvalid_i) begin
                        wr_prio_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                wready_o = ~pending_q & ~wdone_q & ram_accept_i;
                ram_wr_o = wvalid_i & ~pending_q & ~wdone_q;
                if (wvalid_i & wready_o) begin
                    pending_d  = 1'b1;
                    addr_d     = addr_nxt;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == len_q) begin
                        wdone_d = 1'b1;
                    end
                end
                if (wdone_q & ack_take) begin
                    state_d = ST_WRESP;
                    bid_d   = id_q;
                end
            end
            ST_WRESP: begin
                bvalid_o = 1'b1;
                if (bready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                ram_rd_o = ~pending_q & ~rvalid_q & (iss_q <= {1'b0, len_q});
                if (ram_rd_o & ram_accept_i) begin
                    pending_d = 1'b1;
                    addr_d    = addr_nxt;
                    iss_d     = iss_q + 9'd1;
                end
                if (ack_take) begin
                    rvalid_d   = 1'b1;
                    rdata_d    = ram_read_data_i;
                    rid_d      = id_q;
                    rlast_d    = (beat_cnt_q == len_q);
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
                if (rvalid_q & rready_i) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wr_prio_q  <= 1'b1;
            pending_q  <= 1'b0;
            addr_q     <= 32'd0;
            id_q       <= 5'd0;
            len_q      <= 8'd0;
            burst_q    <= 2'd0;
            beat_cnt_q <= 8'd0;
            iss_q      <= 9'd0;
            wdone_q    <= 1'b0;
            bid_q      <= 5'd0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            rid_q      <= 5'd0;
            rlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_prio_q  <= wr_prio_d;
            pending_q  <= pending_d;
            addr_q     <= addr_d;
            id_q       <= id_d;
            len_q      <= len_d;
            burst_q    <= burst_d;
            beat_cnt_q <= beat_cnt_d;
            iss_q      <= iss_d;
            wdone_q    <= wdone_d;
            bid_q      <= bid_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rid_q      <= rid_d;
            rlast_q    <= rlast_d;
        end
    end

    assign bresp_o          = 2'b00;
    assign bid_o            = bid_q;
    assign rvalid_o         = rvalid_q;
    assign rdata_o          = rdata_q;
    assign rresp_o          = 2'b00;
    assign rid_o            = rid_q;
    assign rlast_o          = rlast_q;
    assign ram_addr_o       = addr_q;
    assign ram_wstrb_o      = (state_q == ST_WRITE) ? wstrb_i : 4'd0;
    assign ram_write_data_o = wdata_i;

endmodule

// File: tb/tb_ddr3_axi_burst_responder.sv
// Scoreboard bench for ddr3_axi_burst_responder: expected memory requests,
// B and R responses are queued by the stimulus and popped by a monitor.
module tb_ddr3_axi_burst_responder;

    logic        clk;
    logic        rst;
    logic        awvalid_i, awready_o;
    logic [31:0] awaddr_i;
    logic [4:0]  awid_i;
    logic [7:0]  awlen_i;
    logic [1:0]  awburst_i;
    logic        wvalid_i, wlast_i, wready_o;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        bvalid_o, bready_i;
    logic [1:0]  bresp_o;
    logic [4:0]  bid_o;
    logic        arvalid_i, arready_o;
    logic [31:0] araddr_i;
    logic [4:0]  arid_i;
    logic [7:0]  arlen_i;
    logic [1:0]  arburst_i;
    logic        rvalid_o, rlast_o, rready_i;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic [4:0]  rid_o;
    logic        ram_wr_o, ram_rd_o;
    logic [31:0] ram_addr_o, ram_write_data_o;
    logic [3:0]  ram_wstrb_o;
    logic        ram_accept_i, ram_ack_i;
    logic [31:0] ram_read_data_i;

    ddr3_axi_burst_responder dut (
        .clk_i(clk), .rst_i(rst),
        .awvalid_i(awvalid_i), .awaddr_i(awaddr_i), .awid_i(awid_i),
        .awlen_i(awlen_i), .awburst_i(awburst_i), .awready_o(awready_o),
        .wvalid_i(wvalid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .wlast_i(wlast_i), .wready_o(wready_o),
        .bvalid_o(bvalid_o), .bresp_o(bresp_o), .bid_o(bid_o),
        .bready_i(bready_i),
        .arvalid_i(arvalid_i), .araddr_i(araddr_i), .arid_i(arid_i),
        .arlen_i(arlen_i), .arburst_i(arburst_i), .arready_o(arready_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rresp_o(rresp_o),
        .rid_o(rid_o), .rlast_o(rlast_o), .rready_i(rready_i),
        .ram_wr_o(ram_wr_o), .ram_rd_o(ram_rd_o), .ram_addr_o(ram_addr_o),
        .ram_wstrb_o(ram_wstrb_o), .ram_write_data_o(ram_write_data_o),
        .ram_accept_i(ram_accept_i), .ram_ack_i(ram_ack_i),
        .ram_read_data_i(ram_read_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  id;
        logic        last;
    } rsp_t;

    req_t       req_q[$];
    logic [4:0] b_q[$];
    rsp_t       r_q[$];
    int         total = 0;
    int         bad = 0;
    int         stall_n = 0;
    int         ack_lat = 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL timeout %s: got no handshake want handshake", nm);
    endtask

    task automatic tick_pre();
        @(negedge clk);
        #3;
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        req_q.push_back(req_t'{1'b1, a, d, s});
    endtask

    task automatic exp_rd(input logic [31:0] a, input logic [4:0] id,
                          input logic last);
        req_q.push_back(req_t'{1'b0, a, 32'd0, 4'd0});
        r_q.push_back(rsp_t'{mem_data(a), id, last});
    endtask

    // Backend model and monitor share one process so that the accept
    // decision and the scoreboard see exactly the same sampled values.
    logic        m_acc;
    logic        m_pv, m_pr;
    logic [31:0] m_pd;
    logic [31:0] m_aaddr;
    int          m_acnt, m_scnt;
    req_t        m_req;
    rsp_t        m_rsp;
    logic [4:0]  m_bid;

    initial begin
        m_acnt = 0; m_scnt = 0; m_pv = 0; m_pr = 0; m_pd = 0; m_aaddr = 0;
        ram_accept_i = 1'b1;
        ram_ack_i = 1'b0;
        ram_read_data_i = 32'd0;
        forever begin
            tick_pre();
            m_acc = (ram_wr_o | ram_rd_o) & ram_accept_i;
            if (m_acc) m_aaddr = ram_addr_o;
            if (!rst) begin
                if (m_acc) begin
                    if (req_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL req: got unexpected request at %h want none",
                                 ram_addr_o);
                    end else begin
                        m_req = req_q.pop_front();
                        chk("req_type", 32'(ram_wr_o), 32'(m_req.wr));
                        chk("req_addr", ram_addr_o, m_req.addr);
                        if (m_req.wr) begin
                            chk("req_data", ram_write_data_o, m_req.data);
                            chk("req_strb", 32'(ram_wstrb_o), 32'(m_req.strb));
                        end
                    end
                end
                if (bvalid_o && bready_i) begin
                    if (b_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL b: got unexpected B id %h want none", bid_o);
                    end else begin
                        m_bid = b_q.pop_front();
                        chk("bid", 32'(bid_o), 32'(m_bid));
                        chk("bresp", 32'(bresp_o), 32'd0);
                    end
                end
                if (rvalid_o && rready_i) begin
                    if (r_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL r: got unexpected R %h want none", rdata_o);
                    end else begin
                        m_rsp = r_q.pop_front();
                        chk("rdata", rdata_o, m_rsp.data);
                        chk("rid", 32'(rid_o), 32'(m_rsp.id));
                        chk("rlast", 32'(rlast_o), 32'(m_rsp.last));
                        chk("rresp", 32'(rresp_o), 32'd0);
                    end
                end
                if (m_pv && !m_pr) begin
                    chk("r_hold_valid", 32'(rvalid_o), 32'd1);
                    chk("r_hold_data", rdata_o, m_pd);
                    chk("r_hold_no_rd", 32'(ram_rd_o), 32'd0);
                end
                if (wready_o) chk("wready_accept", 32'(ram_accept_i), 32'd1);
                m_pv = rvalid_o;
                m_pr = rready_i;
                m_pd = rdata_o;
            end else begin
                m_pv = 1'b0;
                m_pr = 1'b0;
            end
            drive();
            ram_ack_i = 1'b0;
            if (m_acc) m_acnt = ack_lat;
            if (m_acnt > 0) begin
                m_acnt--;
                if (m_acnt == 0) begin
                    ram_ack_i = 1'b1;
                    ram_read_data_i = mem_data(m_aaddr);
                end
            end
            if (stall_n == 0) begin
                ram_accept_i = 1'b1;
            end else begin
                if (m_acc) m_scnt = 0;
                else if (m_scnt < stall_n) m_scnt++;
                ram_accept_i = (m_scnt >= stall_n);
            end
        end
    end

    task automatic send_aw(input logic [31:0] a, input logic [4:0] id,
                           input logic [7:0] len, input logic [1:0] b);
        int k;
        awvalid_i = 1'b1; awaddr_i = a; awid_i = id;
        awlen_i = len; awburst_i = b;
        k = 0;
        tick_pre();
        while (!awready_o && k < 300) begin k++; tick_pre(); end
        if (!awready_o) timeout("aw");
        drive();
        awvalid_i = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [4:0] id,
                           input logic [7:0] len, input logic [1:0] b);
        int k;
        arvalid_i = 1'b1; araddr_i = a; arid_i = id;
        arlen_i = len; arburst_i = b;
        k = 0;
        tick_pre();
        while (!arready_o && k < 300) begin k++; tick_pre(); end
        if (!arready_o) timeout("ar");
        drive();
        arvalid_i = 1'b0;
    endtask

    task automatic send_w(input int n, input logic [31:0] d0,
                          input logic [3:0] s);
        int k;
        for (int i = 0; i < n; i++) begin
            wvalid_i = 1'b1; wdata_i = d0 + 32'(i);
            wstrb_i = s; wlast_i = (i == n - 1);
            k = 0;
            tick_pre();
            while (!wready_o && k < 300) begin k++; tick_pre(); end
            if (!wready_o) timeout("w");
            drive();
        end
        wvalid_i = 1'b0;
        wlast_i = 1'b0;
    endtask

    task automatic wait_b();
        int k;
        k = 0;
        tick_pre();
        while (!bvalid_o && k < 300) begin k++; tick_pre(); end
        if (!bvalid_o) timeout("b");
        drive();
    endtask

    task automatic read_rsp(input int n, input int hold);
        int k;
        for (int b = 0; b < n; b++) begin
            k = 0;
            tick_pre();
            while (!rvalid_o && k < 300) begin k++; tick_pre(); end
            if (!rvalid_o) begin
                timeout("r");
                drive();
                return;
            end
            if (b == hold) repeat (5) @(posedge clk);
            drive();
            rready_i = 1'b1;
            tick_pre();
            drive();
            rready_i = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((req_q.size() + b_q.size() + r_q.size()) != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk({nm, "_leftover"}, 32'(req_q.size() + b_q.size() + r_q.size()), 32'd0);
        req_q.delete();
        b_q.delete();
        r_q.delete();
        drive();
    endtask

    task automatic rst_vals(input string nm);
        chk({nm, "_awready"}, 32'(awready_o), 32'd0);
        chk({nm, "_arready"}, 32'(arready_o), 32'd0);
        chk({nm, "_wready"}, 32'(wready_o), 32'd0);
        chk({nm, "_bvalid"}, 32'(bvalid_o), 32'd0);
        chk({nm, "_rvalid"}, 32'(rvalid_o), 32'd0);
        chk({nm, "_ram_wr"}, 32'(ram_wr_o), 32'd0);
        chk({nm, "_ram_rd"}, 32'(ram_rd_o), 32'd0);
        chk({nm, "_bid"}, 32'(bid_o), 32'd0);
        chk({nm, "_rid"}, 32'(rid_o), 32'd0);
        chk({nm, "_rdata"}, rdata_o, 32'd0);
        chk({nm, "_rlast"}, 32'(rlast_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst = 1'b1;
        awvalid_i = 0; awaddr_i = 0; awid_i = 0; awlen_i = 0; awburst_i = 0;
        wvalid_i = 0; wdata_i = 0; wstrb_i = 0; wlast_i = 0;
        bready_i = 1'b1;
        arvalid_i = 0; araddr_i = 0; arid_i = 0; arlen_i = 0; arburst_i = 0;
        rready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick_pre();
        rst_vals("reset");
        drive();

        // Tie from reset: write first, then read
        exp_wr(32'h300, 32'h1111_0000, 4'hF);
        exp_wr(32'h304, 32'h1111_0001, 4'hF);
        b_q.push_back(5'd3);
        exp_rd(32'h400, 5'd4, 1'b1);
        fork
            send_aw(32'h300, 5'd3, 8'd1, 2'b01);
            send_ar(32'h400, 5'd4, 8'd0, 2'b01);
            begin send_w(2, 32'h1111_0000, 4'hF); wait_b(); end
            read_rsp(1, -1);
        join
        drain("tie1");

        // Second tie: round robin gives the read first
        exp_rd(32'h500, 5'd5, 1'b0);
        exp_rd(32'h504, 5'd5, 1'b1);
        exp_wr(32'h600, 32'h2222_0000, 4'h3);
        b_q.push_back(5'd6);
        fork
            send_aw(32'h600, 5'd6, 8'd0, 2'b01);
            send_ar(32'h500, 5'd5, 8'd1, 2'b01);
            begin send_w(1, 32'h2222_0000, 4'h3); wait_b(); end
            read_rsp(2, -1);
        join
        drain("tie2");

        // INCR write len=3
        exp_wr(32'h100, 32'hA000_0000, 4'hF);
        exp_wr(32'h104, 32'hA000_0001, 4'hF);
        exp_wr(32'h108, 32'hA000_0002, 4'hF);
        exp_wr(32'h10C, 32'hA000_0003, 4'hF);
        b_q.push_back(5'd9);
        send_aw(32'h100, 5'd9, 8'd3, 2'b01);
        send_w(4, 32'hA000_0000, 4'hF);
        wait_b();
        drain("incr_wr");

        // WRAP read len=3 from 0x1C
        exp_rd(32'h1C, 5'd2, 1'b0);
        exp_rd(32'h10, 5'd2, 1'b0);
        exp_rd(32'h14, 5'd2, 1'b0);
        exp_rd(32'h18, 5'd2, 1'b1);
        send_ar(32'h1C, 5'd2, 8'd3, 2'b10);
        read_rsp(4, -1);
        drain("wrap_rd");

        // INCR read len=7 with rready held low on the second beat
        for (int i = 0; i < 8; i++)
            exp_rd(32'h200 + 32'(4 * i), 5'd7, i == 7);
        send_ar(32'h200, 5'd7, 8'd7, 2'b01);
        read_rsp(8, 1);
        drain("rready_hold");

        // FIXED write len=2, accept stalled 3 cycles per beat
        stall_n = 3;
        exp_wr(32'h80, 32'h5500_0000, 4'hA);
        exp_wr(32'h80, 32'h5500_0001, 4'hA);
        exp_wr(32'h80, 32'h5500_0002, 4'hA);
        b_q.push_back(5'd1);
        send_aw(32'h80, 5'd1, 8'd2, 2'b00);
        send_w(3, 32'h5500_0000, 4'hA);
        wait_b();
        drain("fixed_stall");
        stall_n = 0;

        // WRAP with len=2 behaves as INCR
        exp_rd(32'h18, 5'd10, 1'b0);
        exp_rd(32'h1C, 5'd10, 1'b0);
        exp_rd(32'h20, 5'd10, 1'b1);
        send_ar(32'h18, 5'd10, 8'd2, 2'b10);
        read_rsp(3, -1);
        drain("wrap_len2");

        // Address arithmetic wraps at 2^32
        exp_wr(32'hFFFF_FFFC, 32'h3300_0000, 4'hF);
        exp_wr(32'h0000_0000, 32'h3300_0001, 4'hF);
        b_q.push_back(5'd11);
        send_aw(32'hFFFF_FFFC, 5'd11, 8'd1, 2'b01);
        send_w(2, 32'h3300_0000, 4'hF);
        wait_b();
        drain("addr_wrap");

        // Reset mid-write with a request outstanding, ack arrives late
        ack_lat = 3;
        exp_wr(32'h700, 32'h7700_0000, 4'hF);
        send_aw(32'h700, 5'd13, 8'd3, 2'b01);
        wvalid_i = 1'b1; wdata_i = 32'h7700_0000; wstrb_i = 4'hF;
        tick_pre();
        for (int k = 0; k < 300 && !wready_o; k++) tick_pre();
        drive();
        wvalid_i = 1'b0;
        rst = 1'b1;
        drive();
        rst = 1'b0;
        tick_pre();
        rst_vals("midrst");
        repeat (6) drive();
        ack_lat = 1;
        drain("midrst");

        exp_wr(32'h800, 32'h8800_0000, 4'hF);
        b_q.push_back(5'd14);
        send_aw(32'h800, 5'd14, 8'd0, 2'b01);
        send_w(1, 32'h8800_0000, 4'hF);
        wait_b();
        exp_rd(32'h900, 5'd15, 1'b1);
        send_ar(32'h900, 5'd15, 8'd0, 2'b01);
        read_rsp(1, -1);
        drain("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
